// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial signed subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int N_BITS_DEFAULT = 8;

  // Signed overflow of a - b: operand signs differ and the result sign left the minuend's.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - borrow_in, with borrow out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic d,
  output logic borrow_out
);

  assign d          = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial signed subtractor, LSB first, with valid/ready on both sides
// and registered adder-style status flags plus overflow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] num1,
  input  logic [N_BITS-1:0] num2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] diff,
  output logic              is_negative,
  output logic              is_zero,
  output logic              is_even,
  output logic              overflow
);

  localparam int                CNT_W    = $clog2(N_BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);

  sub_state_t        state_q, state_d;
  logic [N_BITS-1:0] a_q, a_d;
  logic [N_BITS-1:0] b_q, b_d;
  logic [N_BITS-1:0] res_q, res_d;
  logic [N_BITS-1:0] diff_q, diff_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              borrow_q, borrow_d;
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic              out_valid_q, out_valid_d;
  logic              neg_q, neg_d;
  logic              zero_q, zero_d;
  logic              even_q, even_d;
  logic              ovf_q, ovf_d;

  logic              sub_bit;
  logic              sub_borrow;
  logic [N_BITS-1:0] res_next;

  full_subtractor_bit u_bit (
    .a          (a_q[0]),
    .b          (b_q[0]),
    .borrow_in  (borrow_q),
    .d          (sub_bit),
    .borrow_out (sub_borrow)
  );

  // Result fills from the MSB side so after N_BITS shifts bit 0 sits at the LSB.
  assign res_next = {sub_bit, res_q[N_BITS-1:1]};

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    borrow_d    = borrow_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    out_valid_d = out_valid_q;
    neg_d       = neg_q;
    zero_d      = zero_q;
    even_d      = even_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = RUN;
          a_d      = num1;
          b_d      = num2;
          a_msb_d  = num1[N_BITS-1];
          b_msb_d  = num2[N_BITS-1];
          res_d    = {N_BITS{1'b0}};
          borrow_d = 1'b0;
          cnt_d    = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d      = {1'b0, a_q[N_BITS-1:1]};
        b_d      = {1'b0, b_q[N_BITS-1:1]};
        res_d    = res_next;
        borrow_d = sub_borrow;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          diff_d      = res_next;
          neg_d       = res_next[N_BITS-1];
          zero_d      = (res_next == {N_BITS{1'b0}});
          even_d      = ~res_next[0];
          ovf_d       = sub_overflow(a_msb_q, b_msb_q, res_next[N_BITS-1]);
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= {N_BITS{1'b0}};
      b_q         <= {N_BITS{1'b0}};
      res_q       <= {N_BITS{1'b0}};
      diff_q      <= {N_BITS{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      borrow_q    <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      out_valid_q <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      even_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      borrow_q    <= borrow_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      out_valid_q <= out_valid_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      even_q      <= even_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign diff        = diff_q;
  assign is_negative = neg_q;
  assign is_zero     = zero_q;
  assign is_even     = even_q;
  assign overflow    = ovf_q;

endmodule
